// File: rtl/bank_write_sequencer.sv
// rtl/bank_write_sequencer.sv - synchronised bank decode and setup/write/hold sequencer for parameter RAMs
module bank_write_sequencer #(
  parameter int NUM_BANKS  = 5,
  parameter int BANK_W     = 3,
  parameter int SETUP_CYC  = 2,
  parameter int WR_CYC     = 1,
  parameter int STICKY_SEL = 1,
  parameter int DROP_W     = 8
) (
  input  logic                 CLOCK_25,
  input  logic                 iRST,
  input  logic                 data_ready,
  input  logic [BANK_W-1:0]    bank_adr,
  output logic [NUM_BANKS-1:0] bank_sel,
  output logic                 write,
  output logic                 busy,
  output logic                 bank_err,
  output logic                 overrun,
  output logic [DROP_W-1:0]    drop_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

  localparam logic [3:0]        SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0]        WR_LD    = 4'(WR_CYC - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic                   r_s2;
  logic                   w_rise;
  logic                   w_adr_ok;
  logic [NUM_BANKS-1:0]   w_onehot;

  assign w_rise   = r_s1 & ~r_s2;
  assign w_adr_ok = (32'(bank_adr) < 32'(NUM_BANKS));
  assign w_onehot = NUM_BANKS'(1) << bank_adr;

  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      r_s0     <= 1'b0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      bank_sel <= '0;
      write    <= 1'b0;
      busy     <= 1'b0;
      bank_err <= 1'b0;
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      r_s0     <= data_ready;
      r_s1     <= r_s0;
      r_s2     <= r_s1;
      bank_err <= 1'b0;
      overrun  <= 1'b0;

      // Any new request while a sequence is in flight (HOLD included) is dropped.
      if (w_rise && r_state != IDLE) begin
        overrun <= 1'b1;
        if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            if (w_adr_ok) begin
              bank_sel <= w_onehot;
              r_state  <= SETUP;
              r_cnt    <= SETUP_LD;
              busy     <= 1'b1;
            end else begin
              bank_err <= 1'b1;
              bank_sel <= '0;
            end
          end
        end
        SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= WRITE;
            write   <= 1'b1;
            r_cnt   <= WR_LD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRITE: begin
          if (r_cnt == 4'd0) begin
            write   <= 1'b0;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          if (STICKY_SEL == 0) bank_sel <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_write_sequencer.sv
// tb/tb_bank_write_sequencer.sv - scoreboard bench for bank_write_sequencer
module tb_bank_write_sequencer;

  typedef struct packed {
    logic [4:0] sel;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       dr_a, dr_b;
  logic [2:0] adr_a, adr_b;
  logic [4:0] sel_a, sel_b;
  logic       wr_a, wr_b, busy_a, busy_b, err_a, err_b, ovr_a, ovr_b;
  logic [7:0] drop_a, drop_b;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       q_a[$];
  exp_t       q_b[$];
  logic       wr_a_q = 1'b0;
  logic       wr_b_q = 1'b0;
  int         st_a = 0;
  int         st_b = 0;
  int         exp_drop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_write_sequencer dut_a (
    .CLOCK_25(clk), .iRST(rst), .data_ready(dr_a), .bank_adr(adr_a),
    .bank_sel(sel_a), .write(wr_a), .busy(busy_a), .bank_err(err_a),
    .overrun(ovr_a), .drop_cnt(drop_a)
  );

  bank_write_sequencer #(.SETUP_CYC(3), .WR_CYC(4), .STICKY_SEL(0)) dut_b (
    .CLOCK_25(clk), .iRST(rst), .data_ready(dr_b), .bank_adr(adr_b),
    .bank_sel(sel_b), .write(wr_b), .busy(busy_b), .bank_err(err_b),
    .overrun(ovr_b), .drop_cnt(drop_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write pulses are matched against the scoreboard as they appear.
  always @(negedge clk) begin
    if (wr_a && !wr_a_q) begin
      if (q_a.size() == 0) check("a_wr_unexpected", 32'(1), 32'(0));
      else begin
        check("a_wr_sel", 32'(sel_a), 32'(q_a[0].sel));
        check("a_wr_start", 32'(cyc), 32'(q_a[0].start));
        void'(q_a.pop_front());
      end
      st_a <= cyc;
    end
    if (!wr_a && wr_a_q) check("a_wr_len", 32'(cyc - st_a), 32'(1));
    if (wr_a) check("a_onehot", 32'($onehot(sel_a)), 32'(1));
    wr_a_q <= wr_a;

    if (wr_b && !wr_b_q) begin
      if (q_b.size() == 0) check("b_wr_unexpected", 32'(1), 32'(0));
      else begin
        check("b_wr_sel", 32'(sel_b), 32'(q_b[0].sel));
        check("b_wr_start", 32'(cyc), 32'(q_b[0].start));
        void'(q_b.pop_front());
      end
      st_b <= cyc;
    end
    if (!wr_b && wr_b_q) check("b_wr_len", 32'(cyc - st_b), 32'(4));
    if (wr_b) check("b_onehot", 32'($onehot(sel_b)), 32'(1));
    wr_b_q <= wr_b;
  end

  // Accepted request followed by a second rise landing on edge T+4.
  task automatic pulse_pair(input logic [2:0] adr, input bit detail);
    adr_a = adr;
    dr_a  = 1'b1;
    q_a.push_back('{sel: 5'(5'd1 << adr), start: cyc + 5});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (detail) begin
        check("ovr_pulse", 32'(ovr_a), 32'(k == 4));
        check("drop_one", 32'(drop_a), (k >= 4) ? 32'(1) : 32'(0));
      end
      if (k == 0) dr_a = 1'b0;
      else if (k == 1) dr_a = 1'b1;
      else if (k == 2) dr_a = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; dr_a = 1'b0; dr_b = 1'b0; adr_a = 3'd0; adr_b = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel_a), 32'(0));
    check("rst_write", 32'(wr_a), 32'(0));
    check("rst_busy", 32'(busy_a), 32'(0));
    check("rst_err", 32'(err_a), 32'(0));
    check("rst_ovr", 32'(ovr_a), 32'(0));
    check("rst_drop", 32'(drop_a), 32'(0));
    check("rst_b_sel", 32'(sel_b), 32'(0));
    check("rst_b_busy", 32'(busy_b), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Default timing, bank 2, sticky select.
    adr_a = 3'd2; dr_a = 1'b1;
    q_a.push_back('{sel: 5'b00100, start: cyc + 5});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("s1_sel", 32'(sel_a), (k >= 2) ? 32'h4 : 32'h0);
      check("s1_write", 32'(wr_a), 32'(k == 4));
      check("s1_busy", 32'(busy_a), 32'(k >= 2 && k <= 5));
      if (k == 1) dr_a = 1'b0;
    end

    // Out-of-range bank.
    adr_a = 3'd6; dr_a = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("s2_err", 32'(err_a), 32'(k == 2));
      check("s2_sel", 32'(sel_a), (k >= 2) ? 32'h0 : 32'h4);
      check("s2_write", 32'(wr_a), 32'(0));
      check("s2_busy", 32'(busy_a), 32'(0));
      if (k == 0) dr_a = 1'b0;
    end

    // Overrun then saturation of the drop counter.
    pulse_pair(3'd0, 1'b1);
    exp_drop = 1;
    for (int i = 0; i < 300; i++) begin
      pulse_pair(3'(i % 5), 1'b0);
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      check("drop_sat", 32'(drop_a), 32'(exp_drop));
    end

    // Long setup/write, non-sticky select.
    adr_b = 3'd4; dr_b = 1'b1;
    q_b.push_back('{sel: 5'b10000, start: cyc + 6});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("s4_sel", 32'(sel_b), (k >= 2 && k <= 9) ? 32'h10 : 32'h0);
      check("s4_write", 32'(wr_b), 32'(k >= 5 && k <= 8));
      check("s4_busy", 32'(busy_b), 32'(k >= 2 && k <= 9));
      if (k == 0) dr_b = 1'b0;
    end

    // Reset during WRITE with data_ready held through release.
    adr_a = 3'd3; dr_a = 1'b1;
    q_a.push_back('{sel: 5'b01000, start: cyc + 5});
    repeat (5) @(negedge clk);
    check("s5_write_pre", 32'(wr_a), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check("s5_write_rst", 32'(wr_a), 32'(0));
    check("s5_sel_rst", 32'(sel_a), 32'(0));
    check("s5_busy_rst", 32'(busy_a), 32'(0));
    rst = 1'b0;
    q_a.push_back('{sel: 5'b01000, start: cyc + 5});
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("s6_no_ovr", 32'(ovr_a), 32'(0));
    end
    dr_a = 1'b0;
    repeat (10) @(negedge clk);
    check("s6_busy_end", 32'(busy_a), 32'(0));
    check("q_a_empty", 32'(q_a.size()), 32'(0));
    check("q_b_empty", 32'(q_b.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
